// File: rtl/mem_seq.sv
// Memory-stage sequencer: splits one scalar or vector load/store into
// element-wide req/ack beats and stalls the pipeline until the last beat is acknowledged.
module mem_seq #(
    parameter int REGI_SIZE  = 16,
    parameter int ELEM_SIZE  = 8,
    parameter int VECT_SIZE  = 8,
    parameter int MEMO_LINES = 64,
    parameter int ADDR_BITS  = $clog2(MEMO_LINES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           rd_i,
    input  logic                           wr_i,
    input  logic                           vec_i,
    input  logic [ADDR_BITS-1:0]           addr_i,
    input  logic [REGI_SIZE-1:0]           sdata_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] vdata_i,
    output logic                           stall_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [REGI_SIZE-1:0]           srdata_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] vrdata_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_BITS-1:0]           mem_addr_o,
    output logic [ELEM_SIZE-1:0]           mem_wdata_o,
    input  logic                           mem_ack_i,
    input  logic [ELEM_SIZE-1:0]           mem_rdata_i
);
    localparam int SCAL_BEATS = REGI_SIZE / ELEM_SIZE;
    localparam int VECT_W     = ELEM_SIZE * VECT_SIZE;
    localparam int BUF_W      = (VECT_W > REGI_SIZE) ? VECT_W : REGI_SIZE;
    localparam int MAX_BEATS  = (VECT_SIZE > SCAL_BEATS) ? VECT_SIZE : SCAL_BEATS;
    localparam int CNT_BITS   = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state, stateNext;
    logic                accept, lastBeat, beatAck;
    logic                vecQ;
    logic [CNT_BITS-1:0] beat, beatNext, lastIdx;
    logic [BUF_W-1:0]    wBuf, rBuf, rBufNext;

    assign beatAck  = (state == ACCESS) && mem_ack_i;
    assign beatNext = beat + 1'b1;
    assign lastIdx  = vecQ ? CNT_BITS'(VECT_SIZE - 1) : CNT_BITS'(SCAL_BEATS - 1);
    assign lastBeat = (beat == lastIdx);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        stall_o   = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && (rd_i ^ wr_i)) begin
                    accept    = 1'b1;
                    stall_o   = 1'b1;
                    stateNext = ACCESS;
                end else if (start_i && rd_i && wr_i) begin
                    err_o = 1'b1;
                end
            end
            ACCESS: begin
                stall_o = 1'b1;
                if (mem_ack_i && lastBeat) stateNext = DONE;
            end
            DONE: begin
                // Pipeline advances this cycle, so start_i still reflects the finished op.
                done_o    = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Read buffer including the element arriving this cycle, so the final
    // beat can land straight in the result register.
    always_comb begin
        rBufNext = rBuf;
        rBufNext[beat*ELEM_SIZE +: ELEM_SIZE] = mem_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vecQ        <= 1'b0;
            beat        <= '0;
            wBuf        <= '0;
            rBuf        <= '0;
            srdata_o    <= '0;
            vrdata_o    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else if (accept) begin
            vecQ        <= vec_i;
            beat        <= '0;
            wBuf        <= vec_i ? BUF_W'(vdata_i) : BUF_W'(sdata_i);
            mem_req_o   <= 1'b1;
            mem_we_o    <= wr_i;
            mem_addr_o  <= addr_i;
            mem_wdata_o <= vec_i ? vdata_i[ELEM_SIZE-1:0] : sdata_i[ELEM_SIZE-1:0];
        end else if (beatAck) begin
            if (!mem_we_o) rBuf <= rBufNext;
            if (lastBeat) begin
                mem_req_o <= 1'b0;
                mem_we_o  <= 1'b0;
                if (!mem_we_o) begin
                    if (vecQ) vrdata_o <= rBufNext[VECT_W-1:0];
                    else      srdata_o <= rBufNext[REGI_SIZE-1:0];
                end
            end else begin
                beat        <= beatNext;
                mem_addr_o  <= mem_addr_o + 1'b1;  // wraps past the top line
                mem_wdata_o <= wBuf[beatNext*ELEM_SIZE +: ELEM_SIZE];
            end
        end
    end
endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq: memory responder with programmable ack delay,
// expected beats queued at stimulus time and compared against observed beats.
module tb_mem_seq;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, rd_i, wr_i, vec_i;
    logic [5:0]  addr_i;
    logic [15:0] sdata_i;
    logic [63:0] vdata_i;
    logic        stall_o, done_o, err_o;
    logic [15:0] srdata_o;
    logic [63:0] vrdata_o;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [5:0]  mem_addr_o;
    logic [7:0]  mem_wdata_o, mem_rdata_i;

    typedef struct packed {
        logic [5:0] addr;
        logic       we;
        logic [7:0] data;
    } beat_t;

    beat_t       expQ[$];
    beat_t       obsQ[$];
    logic [7:0]  mem [64];
    logic [15:0] expS;
    logic [63:0] expV;
    int          errors = 0;
    int          checks = 0;
    int          stallBeat = -1;
    int          stallCycles = 0;
    int          beatIdx, waited;

    mem_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rd_i(rd_i), .wr_i(wr_i),
        .vec_i(vec_i), .addr_i(addr_i), .sdata_i(sdata_i), .vdata_i(vdata_i),
        .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .srdata_o(srdata_o),
        .vrdata_o(vrdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Responder: ack every requested cycle except while holding off the chosen beat.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || !mem_req_o) begin
            beatIdx <= 0;
            waited  <= 0;
        end else if (mem_ack_i) begin
            beatIdx <= beatIdx + 1;
            waited  <= 0;
        end else begin
            waited <= waited + 1;
        end
    end
    assign mem_ack_i   = mem_req_o && !(beatIdx == stallBeat && waited < stallCycles);
    assign mem_rdata_i = mem[mem_addr_o];

    task automatic drive(input logic s, r, w, v, input logic [5:0] a,
                         input logic [15:0] sd, input logic [63:0] vd);
        start_i = s; rd_i = r; wr_i = w; vec_i = v; addr_i = a; sdata_i = sd; vdata_i = vd;
    endtask

    // Called at a negedge right after driving an accepted request (cycle t).
    // Returns cycle offset of done_o and number of stalled cycles; collects beats.
    task automatic runOp(input int maxCyc, output int doneAt, output int stallCyc);
        doneAt = -1;
        stallCyc = 0;
        #1;
        if (stall_o) stallCyc++;
        for (int i = 1; i <= maxCyc && doneAt < 0; i++) begin
            @(negedge clk_i);
            if (stall_o) stallCyc++;
            if (mem_req_o && mem_ack_i)
                obsQ.push_back('{mem_addr_o, mem_we_o, mem_we_o ? mem_wdata_o : 8'h00});
            if (done_o) doneAt = i;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({stall_o, done_o, err_o, srdata_o, vrdata_o, mem_req_o, mem_we_o,
             mem_addr_o, mem_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b done=%b err=%b sr=%h vr=%h req=%b we=%b addr=%h wd=%h, want all 0",
                     stall_o, done_o, err_o, srdata_o, vrdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
    endtask

    task automatic test_scalar_store;
        int doneAt, stallCyc;
        beat_t e, o;
        expQ.push_back('{6'd5, 1'b1, 8'hEF});
        expQ.push_back('{6'd6, 1'b1, 8'hBE});
        drive(1, 0, 1, 0, 6'd5, 16'hBEEF, 64'h0);
        runOp(30, doneAt, stallCyc);
        start_i = 0;
        checks++;
        if (doneAt !== 3) begin errors++; $display("FAIL sst_latency: done at t+%0d, want t+3", doneAt); end
        checks++;
        if (stallCyc !== 3) begin errors++; $display("FAIL sst_stall: %0d stall cycles, want 3", stallCyc); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL sst_beats: %0d beats, want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL sst_beat: got %h want %h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        checks++;
        if ({srdata_o, vrdata_o} !== {expS, expV}) begin
            errors++; $display("FAIL sst_results: sr=%h vr=%h want sr=%h vr=%h", srdata_o, vrdata_o, expS, expV);
        end
    endtask

    task automatic test_vector_load;
        int doneAt, stallCyc;
        beat_t e, o;
        stallBeat = 3; stallCycles = 2;
        for (int k = 0; k < 8; k++) begin
            expQ.push_back('{6'(10 + k), 1'b0, 8'h00});
            expV[k*8 +: 8] = mem[10 + k];
        end
        drive(1, 1, 0, 1, 6'd10, 16'hFFFF, 64'hDEAD_BEEF_0BAD_F00D);
        runOp(40, doneAt, stallCyc);
        start_i = 0;
        stallBeat = -1;
        checks++;
        if (doneAt !== 11) begin errors++; $display("FAIL vld_latency: done at t+%0d, want t+11", doneAt); end
        checks++;
        if (vrdata_o !== 64'h0706050403020100) begin
            errors++; $display("FAIL vld_data: vr=%h want 0706050403020100", vrdata_o);
        end
        checks++;
        if (srdata_o !== expS) begin errors++; $display("FAIL vld_sr_kept: sr=%h want %h", srdata_o, expS); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL vld_beats: %0d beats, want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL vld_beat: got %h want %h", o, e); end
        end
        expQ.delete(); obsQ.delete();
    endtask

    task automatic test_wrap;
        int doneAt, stallCyc;
        beat_t e, o;
        logic [63:0] vd;
        vd = {$urandom, $urandom};
        for (int k = 0; k < 8; k++) expQ.push_back('{6'((62 + k) % 64), 1'b1, vd[k*8 +: 8]});
        drive(1, 0, 1, 1, 6'd62, 16'h0, vd);
        runOp(30, doneAt, stallCyc);
        start_i = 0;
        checks++;
        if (doneAt !== 9) begin errors++; $display("FAIL wrap_latency: done at t+%0d, want t+9", doneAt); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL wrap_beats: %0d beats, want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL wrap_beat: got %h want %h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        checks++;
        if (vrdata_o !== expV) begin errors++; $display("FAIL wrap_vr_kept: vr=%h want %h", vrdata_o, expV); end
    endtask

    task automatic test_illegal;
        @(negedge clk_i);
        drive(1, 1, 1, 0, 6'd3, 16'h1111, 64'h0);
        #1;
        checks++;
        if ({err_o, stall_o} !== 2'b10) begin
            errors++; $display("FAIL ill_pulse: err=%b stall=%b want err=1 stall=0", err_o, stall_o);
        end
        @(negedge clk_i);
        start_i = 0;
        #1;
        checks++;
        if ({err_o, mem_req_o, stall_o} !== 3'b000) begin
            errors++; $display("FAIL ill_after: err=%b req=%b stall=%b want 000", err_o, mem_req_o, stall_o);
        end
        @(negedge clk_i);
        checks++;
        if ({mem_req_o, done_o} !== 2'b00) begin
            errors++; $display("FAIL ill_idle: req=%b done=%b want 00", mem_req_o, done_o);
        end
    endtask

    task automatic test_reset_mid;
        int doneAt, stallCyc;
        beat_t e, o;
        @(negedge clk_i);
        drive(1, 1, 0, 1, 6'd30, 16'h0, 64'h0);
        repeat (5) @(negedge clk_i);
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 6'd34) begin
            errors++; $display("FAIL rst_beat4: req=%b addr=%0d want req=1 addr=34", mem_req_o, mem_addr_o);
        end
        rst_i = 0;
        start_i = 0;
        expS = '0; expV = '0;
        #1;
        checks++;
        if ({stall_o, done_o, err_o, srdata_o, vrdata_o, mem_req_o, mem_we_o,
             mem_addr_o, mem_wdata_o} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: stall=%b req=%b sr=%h vr=%h addr=%h, want all 0",
                               stall_o, mem_req_o, srdata_o, vrdata_o, mem_addr_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        expQ.push_back('{6'd40, 1'b0, 8'h00});
        expQ.push_back('{6'd41, 1'b0, 8'h00});
        expS = {mem[41], mem[40]};
        drive(1, 1, 0, 0, 6'd40, 16'h0, 64'h0);
        runOp(30, doneAt, stallCyc);
        start_i = 0;
        checks++;
        if (doneAt !== 3) begin errors++; $display("FAIL rst_new_latency: done at t+%0d, want t+3", doneAt); end
        checks++;
        if ({srdata_o, vrdata_o} !== {expS, expV}) begin
            errors++; $display("FAIL rst_new_data: sr=%h vr=%h want sr=%h vr=%h", srdata_o, vrdata_o, expS, expV);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL rst_new_beat: got %h want %h", o, e); end
        end
        expQ.delete(); obsQ.delete();
    endtask

    task automatic test_back_to_back;
        int doneAt, stallCyc;
        beat_t e, o;
        @(negedge clk_i);
        expQ.push_back('{6'd63, 1'b0, 8'h00});
        expQ.push_back('{6'd0, 1'b0, 8'h00});
        expQ.push_back('{6'd7, 1'b1, 8'h34});
        expQ.push_back('{6'd8, 1'b1, 8'h12});
        expS = {mem[0], mem[63]};
        drive(1, 1, 0, 0, 6'd63, 16'h0, 64'h0);
        runOp(30, doneAt, stallCyc);
        checks++;
        if (doneAt !== 3) begin errors++; $display("FAIL b2b_first_latency: done at t+%0d, want t+3", doneAt); end
        // Pipeline presents the next op while still in the DONE cycle.
        drive(1, 0, 1, 0, 6'd7, 16'h1234, 64'h0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_done_stall: stall=%b want 0", stall_o); end
        @(negedge clk_i);
        runOp(30, doneAt, stallCyc);
        start_i = 0;
        checks++;
        if (doneAt !== 3) begin errors++; $display("FAIL b2b_second_latency: done at t+%0d, want t+3", doneAt); end
        checks++;
        if (stallCyc !== 3) begin errors++; $display("FAIL b2b_second_stall: %0d stall cycles, want 3", stallCyc); end
        checks++;
        if (obsQ.size() !== expQ.size()) begin
            errors++; $display("FAIL b2b_beats: %0d beats, want %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_beat: got %h want %h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        checks++;
        if (srdata_o !== expS) begin errors++; $display("FAIL b2b_sr: sr=%h want %h", srdata_o, expS); end
        @(negedge clk_i);
        checks++;
        if ({done_o, mem_req_o, stall_o} !== 3'b000) begin
            errors++; $display("FAIL b2b_quiet: done=%b req=%b stall=%b want 000", done_o, mem_req_o, stall_o);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
        for (int k = 0; k < 8; k++) mem[10 + k] = 8'(k);
        expS = '0;
        expV = '0;
        rst_i = 0;
        drive(0, 0, 0, 0, 6'd0, 16'h0, 64'h0);
        repeat (2) @(negedge clk_i);
        test_reset;
        rst_i = 1;
        @(negedge clk_i);
        test_scalar_store;
        @(negedge clk_i);
        test_vector_load;
        @(negedge clk_i);
        test_wrap;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Memory-stage sequencer between the EX/MEM pipeline register and the byte-wide data memory.
- Turns one scalar (REGI_SIZE) or vector (ELEM_SIZE*VECT_SIZE) load/store into a series of element-wide memory beats using a req/ack handshake.
- Stalls the pipeline until all beats finish, then returns the assembled read data.

Parameters:
- REGI_SIZE, 16, scalar register width; must be a multiple of ELEM_SIZE.
- ELEM_SIZE, 8, memory word and vector element width.
- VECT_SIZE, 8, elements per vector.
- MEMO_LINES, 64, number of memory words; must be a power of two.
- ADDR_BITS, $clog2(MEMO_LINES), address width.

Ports:
- clk_i, input, 1: clock. Single clock domain.
- rst_i, input, 1: reset. Asynchronous, active-low.
- start_i, input, 1: MEM-stage access request (enableMem). Held by the pipeline while stalled.
- rd_i, input, 1: load (flagMemRead).
- wr_i, input, 1: store (flagMemWrite).
- vec_i, input, 1: 1 = vector access, 0 = scalar access.
- addr_i, input, ADDR_BITS: base word address.
- sdata_i, input, REGI_SIZE: scalar store data.
- vdata_i, input, ELEM_SIZE*VECT_SIZE: vector store data.
- stall_o, output, 1: pipeline hold.
- done_o, output, 1: one-cycle completion pulse.
- err_o, output, 1: one-cycle illegal-request pulse.
- srdata_o, output, REGI_SIZE: last scalar load result.
- vrdata_o, output, ELEM_SIZE*VECT_SIZE: last vector load result.
- mem_req_o, output, 1: memory beat request.
- mem_we_o, output, 1: beat is a write.
- mem_addr_o, output, ADDR_BITS: beat address.
- mem_wdata_o, output, ELEM_SIZE: beat write data.
- mem_ack_i, input, 1: beat accepted; read data valid in the same cycle.
- mem_rdata_i, input, ELEM_SIZE: beat read data.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State returns to IDLE.
  - All outputs go to 0, including srdata_o and vrdata_o.
  - Beat counter and latched request are cleared.
  - Reset mid-operation abandons the access; beats already written are not undone.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Accept when start_i=1 and exactly one of rd_i/wr_i is 1.
  - On accept, latch addr, we=wr_i, vec, and store data; clear the beat counter; go to ACCESS.
  - start_i=1 with rd_i=wr_i=1 is illegal: err_o pulses for one cycle, nothing is latched, stall_o stays 0, state stays IDLE.
  - start_i=1 with rd_i=wr_i=0: no action.
- Beat count N:
  - Scalar: N = REGI_SIZE/ELEM_SIZE (default 2).
  - Vector: N = VECT_SIZE (default 8).
  - Beat k moves data slice [k*ELEM_SIZE +: ELEM_SIZE] (little-endian element order).
  - Beat k address = (base + k) mod MEMO_LINES, i.e. wraps past the top address.
- ACCESS:
  - mem_req_o is registered; it is high for every ACCESS cycle.
  - mem_addr_o, mem_we_o and mem_wdata_o stay stable until mem_ack_i.
  - On ack in a read beat, mem_rdata_i is stored into slot k of an internal buffer.
  - On ack with k < N-1: k increments, and the next beat's address/data are presented the next cycle while req stays high.
  - On ack with k = N-1: go to DONE; mem_req_o is 0 in DONE.
  - No timeout: mem_ack_i may be delayed indefinitely.
- DONE (exactly one cycle):
  - done_o = 1.
  - For a read, the buffer is copied to srdata_o (scalar) or vrdata_o (vector) on entry to DONE; the other result register is unchanged.
  - Writes never modify srdata_o or vrdata_o.
  - start_i is ignored in DONE (the pipeline advances this cycle); next state is IDLE.
- stall_o (combinational):
  - 1 in the IDLE accept cycle.
  - 1 in every ACCESS cycle.
  - 0 in DONE and otherwise.
- Latency:
  - Accept at cycle t; first req at t+1.
  - With ack on every requested cycle, done_o asserts at t+N+1.
  - Each wait cycle adds one.
- Back-to-back accesses: a new accept is possible at the earliest in the IDLE cycle right after DONE.
- Result registers hold their value until the next completed read of the same kind.

Test Plan:
1. Scalar store: addr=5, sdata=0xBEEF, ack always 1.
   - Beats (5,0xEF), (6,0xBE) with we=1.
   - done_o at t+3; stall_o high from t through t+2.
2. Vector load: addr=10, memory[10..17]=0x00..0x07, ack delayed 2 cycles on beat 3.
   - vrdata_o = 0x0706050403020100.
   - done_o at t+11; srdata_o unchanged.
3. Wrap-around: vector store at addr=62.
   - Beat addresses 62, 63, 0, 1, 2, 3, 4, 5.
4. Illegal request: start_i=1, rd_i=wr_i=1.
   - err_o pulses one cycle; no mem_req_o; stall_o=0.
5. Reset mid-operation: assert rst_i low during beat 4 of a vector load.
   - All outputs 0 immediately, state IDLE, vrdata_o=0.
   - A new scalar load after release completes normally.
6. Back-to-back: scalar load followed by scalar store, start_i held.
   - Exactly one done_o per op; no duplicate accept in the DONE cycle.
   - The second op's accept occurs in the cycle after DONE.
